uart_tx_fifo_reader: RTL and testbench

UART transmitter that drains a transmit FIFO through the FIFO's read side (rd/empty/read data) and serialises each word onto the tx line.
- Frame: start bit, DBIT data bits LSB-first, optional parity bit, stop bits.
- Sits between the TX FIFO and the pad.
- Shares the 16x oversampling tick (s_tick) from the common baud generator with the UART receiver.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_fifo_reader.sv | 145 ++++++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding and oversampling constants.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam int OVERSAMPLE = 16;

    // Stop-period lengths in s_tick units: 1, 1.5 and 2 stop bits.
    localparam int SB_1   = 16;
    localparam int SB_1P5 = 24;
    localparam int SB_2   = 32;

endpackage

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops words from a first-word-fall-through TX FIFO and
// serialises them as start / DBIT data (LSB first) / optional parity / stop.
module uart_tx_fifo_reader
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = SB_1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            tx_en,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_rdata,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int              BW        = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [4:0]      TICK_LAST = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]      STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [BW-1:0]   BIT_LAST  = BW'(DBIT - 1);

    tx_state_t       state_q, state_d;
    logic [4:0]      tick_q, tick_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            parity_q, parity_d;
    logic            tx_q, tx_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

    // tx_d always carries the level of the state being entered, so the line is
    // a clean register output that only moves on state or bit boundaries.
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        tx_d         = tx_q;
        fifo_rd      = 1'b0;
        tx_done_tick = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_en && !fifo_empty) begin
                    // Gated so a FIFO that keeps running through our reset never loses its head word.
                    fifo_rd  = reset_n;
                    shift_d  = fifo_rdata;
                    parity_d = (^fifo_rdata) ^ (PARITY_ODD != 0);
                    tick_d   = '0;
                    tx_d     = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        tx_d    = shift_q[0];
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == BIT_LAST) begin
                            if (PARITY_EN != 0) begin
                                tx_d    = parity_q;
                                state_d = PARITY;
                            end else begin
                                tx_d    = 1'b1;
                                state_d = STOP;
                            end
                        end else begin
                            bit_d = bit_q + 1'b1;
                            tx_d  = shift_d[0];
                        end
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tick_q == STOP_LAST) begin
                        tick_d       = '0;
                        tx_d         = 1'b1;
                        tx_done_tick = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Self-checking bench: three transmitter configurations fed from bench-side FIFOs,
// compared every cycle against a segment-list model of the serial frame.
`timescale 1ns/1ps
module tb_uart_tx_fifo_reader;
    import uart_pkg::*;

    localparam int NI = 3;
    localparam int SBT  [NI] = '{SB_1, SB_2, SB_1P5};
    localparam int PEN  [NI] = '{0, 1, 1};
    localparam int PODD [NI] = '{0, 0, 1};

    logic          clk = 1'b0;
    logic          reset_n;
    logic          s_tick;
    logic [NI-1:0] txEn;
    logic [NI-1:0] fifoEmpty, fifoRd, txLine, txBusy, txDone;
    logic [7:0]    rdata [NI];

    logic [7:0]    fmem [NI][256];
    logic [7:0]    wp [NI] = '{default: 8'd0};
    logic [7:0]    rp [NI] = '{default: 8'd0};
    logic          popReq [NI] = '{default: 1'b0};

    int tickPeriod = 4;
    int tickPh = 0;
    int nChecks = 0;
    int nErrors = 0;
    int negCnt = 0;

    logic inFrame [NI];
    logic expTx [NI];
    logic segLvl [NI][12];
    int   segLen [NI][12];
    int   nSeg [NI], segIdx [NI], segCnt [NI];

    logic prevTx [NI] = '{default: 1'b1};
    int   edgeN [NI][1024];
    int   nEdge [NI] = '{default: 0};
    int   popCnt [NI] = '{default: 0};
    int   doneCnt [NI] = '{default: 0};
    int   doneN [NI] = '{default: 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gFifo
        assign fifoEmpty[g] = (wp[g] == rp[g]);
        assign rdata[g]     = fmem[g][rp[g]];
    end

    uart_tx_fifo_reader #(.DBIT(8), .SB_TICK(SB_1), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_en(txEn[0]),
        .fifo_empty(fifoEmpty[0]), .fifo_rdata(rdata[0]), .fifo_rd(fifoRd[0]),
        .tx(txLine[0]), .tx_busy(txBusy[0]), .tx_done_tick(txDone[0]));

    uart_tx_fifo_reader #(.DBIT(8), .SB_TICK(SB_2), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_en(txEn[1]),
        .fifo_empty(fifoEmpty[1]), .fifo_rdata(rdata[1]), .fifo_rd(fifoRd[1]),
        .tx(txLine[1]), .tx_busy(txBusy[1]), .tx_done_tick(txDone[1]));

    uart_tx_fifo_reader #(.DBIT(8), .SB_TICK(SB_1P5), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_en(txEn[2]),
        .fifo_empty(fifoEmpty[2]), .fifo_rdata(rdata[2]), .fifo_rd(fifoRd[2]),
        .tx(txLine[2]), .tx_busy(txBusy[2]), .tx_done_tick(txDone[2]));

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // A frame is a list of (level, length-in-ticks) segments built from the popped word.
    task automatic buildFrame(input int i, input logic [7:0] w);
        int n;
        logic p;
        n = 0;
        segLvl[i][n] = 1'b0; segLen[i][n] = 16; n++;
        for (int b = 0; b < 8; b++) begin
            segLvl[i][n] = w[b]; segLen[i][n] = 16; n++;
        end
        if (PEN[i] != 0) begin
            p = ^w;
            if (PODD[i] != 0) p = ~p;
            segLvl[i][n] = p; segLen[i][n] = 16; n++;
        end
        segLvl[i][n] = 1'b1; segLen[i][n] = SBT[i]; n++;
        nSeg[i] = n;
    endtask

    // Compare outputs for the current cycle, then advance the model across the coming edge.
    task automatic modelStep(input int i);
        logic eRd, eDone, eBusy;
        eRd = 1'b0; eDone = 1'b0; eBusy = 1'b0;
        if (!reset_n) begin
            inFrame[i] = 1'b0;
            expTx[i]   = 1'b1;
        end else if (inFrame[i]) begin
            eBusy = 1'b1;
            eDone = s_tick && (segIdx[i] == nSeg[i] - 1) && (segCnt[i] == segLen[i][segIdx[i]] - 1);
        end else begin
            eRd = txEn[i] && !fifoEmpty[i];
        end
        checkOutput($sformatf("tx[%0d]@%0d", i, negCnt), int'(txLine[i]), int'(expTx[i]));
        checkOutput($sformatf("fifo_rd[%0d]@%0d", i, negCnt), int'(fifoRd[i]), int'(eRd));
        checkOutput($sformatf("tx_busy[%0d]@%0d", i, negCnt), int'(txBusy[i]), int'(eBusy));
        checkOutput($sformatf("tx_done_tick[%0d]@%0d", i, negCnt), int'(txDone[i]), int'(eDone));
        if (reset_n) begin
            if (inFrame[i]) begin
                if (s_tick) begin
                    segCnt[i]++;
                    if (segCnt[i] == segLen[i][segIdx[i]]) begin
                        segIdx[i]++;
                        segCnt[i] = 0;
                        if (segIdx[i] == nSeg[i]) begin
                            inFrame[i] = 1'b0;
                            expTx[i]   = 1'b1;
                        end else begin
                            expTx[i] = segLvl[i][segIdx[i]];
                        end
                    end
                end
            end else if (eRd) begin
                buildFrame(i, rdata[i]);
                inFrame[i] = 1'b1;
                segIdx[i]  = 0;
                segCnt[i]  = 0;
                expTx[i]   = segLvl[i][0];
            end
        end
    endtask

    // Per-cycle compare plus event logging used by the directed timing checks.
    always @(negedge clk) begin
        negCnt++;
        for (int i = 0; i < NI; i++) begin
            popReq[i] = fifoRd[i] && reset_n;
            modelStep(i);
            if (reset_n) begin
                if (txLine[i] != prevTx[i] && nEdge[i] < 1024) begin
                    edgeN[i][nEdge[i]] = negCnt;
                    nEdge[i]++;
                end
                if (fifoRd[i]) popCnt[i]++;
                if (txDone[i]) begin
                    doneCnt[i]++;
                    doneN[i] = negCnt;
                end
            end
            prevTx[i] = txLine[i];
        end
    end

    // The bench FIFO advances on the edge where the DUT pops.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++)
            if (popReq[i]) rp[i] <= rp[i] + 8'd1;
    end

    // Baud tick source: fixed period, or random when tickPeriod is 0.
    initial begin
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tickPeriod == 0) begin
                s_tick = ($urandom_range(0, 2) == 0);
            end else begin
                tickPh = (tickPh + 1) % tickPeriod;
                s_tick = (tickPh == 0);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int i, input logic [7:0] w);
        fmem[i][wp[i]] = w;
        wp[i] = wp[i] + 8'd1;
    endtask

    task automatic waitIdle(input int maxCycles);
        int n;
        n = 0;
        do begin
            cycles(1);
            n++;
        end while (!(fifoEmpty == '1 && txBusy == '0) && n < maxCycles);
        checkOutput("idle within budget", int'(fifoEmpty == '1 && txBusy == '0), 1);
    endtask

    task automatic waitPop(input int i, input int target, input int maxCycles);
        int n;
        n = 0;
        while (popCnt[i] < target && n < maxCycles) begin
            cycles(1);
            n++;
        end
        checkOutput("pop within budget", int'(popCnt[i] >= target), 1);
    endtask

    task automatic applyStimulus();
        int bE [NI];
        int bP [NI];
        int bD [NI];
        int expD0 [6] = '{64, 128, 192, 320, 384, 448};
        logic [7:0] lvl;

        reset_n = 1'b0;
        txEn = '0;
        cycles(5);
        reset_n = 1'b1;
        txEn = '1;

        // Empty FIFO with tx_en high: line stays idle, nothing popped.
        cycles(200);
        for (int i = 0; i < NI; i++) checkOutput($sformatf("no pop while empty[%0d]", i), popCnt[i], 0);

        // One frame per configuration; bit boundaries pinned by hand-computed clk offsets.
        for (int i = 0; i < NI; i++) begin bE[i] = nEdge[i]; bP[i] = popCnt[i]; bD[i] = doneCnt[i]; end
        push(0, 8'hA5);
        push(1, 8'h07);
        push(2, 8'h07);
        waitIdle(3000);
        checkOutput("A5 edge count", nEdge[0] - bE[0], 8);
        for (int k = 0; k < 6; k++)
            checkOutput($sformatf("A5 edge %0d offset", k + 2), edgeN[0][bE[0] + 2 + k] - edgeN[0][bE[0] + 1], expD0[k]);
        checkOutput("A5 done offset", doneN[0] - edgeN[0][bE[0] + 1], 575);
        checkOutput("07 even edge count", nEdge[1] - bE[1], 4);
        checkOutput("07 even bit3 fall", edgeN[1][bE[1] + 2] - edgeN[1][bE[1] + 1], 192);
        checkOutput("07 even parity rise", edgeN[1][bE[1] + 3] - edgeN[1][bE[1] + 1], 512);
        checkOutput("07 even 2-stop done offset", doneN[1] - edgeN[1][bE[1] + 1], 703);
        checkOutput("07 odd edge count", nEdge[2] - bE[2], 4);
        checkOutput("07 odd stop rise", edgeN[2][bE[2] + 3] - edgeN[2][bE[2] + 1], 576);
        checkOutput("07 odd 1.5-stop done offset", doneN[2] - edgeN[2][bE[2] + 1], 671);
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("single pop[%0d]", i), popCnt[i] - bP[i], 1);
            checkOutput($sformatf("single done[%0d]", i), doneCnt[i] - bD[i], 1);
        end

        // Back-to-back words.
        for (int i = 0; i < NI; i++) begin
            bP[i] = popCnt[i]; bD[i] = doneCnt[i];
            push(i, 8'h3C); push(i, 8'hFF); push(i, 8'h00);
        end
        waitIdle(8000);
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("burst pops[%0d]", i), popCnt[i] - bP[i], 3);
            checkOutput($sformatf("burst dones[%0d]", i), doneCnt[i] - bD[i], 3);
        end

        // Reset during data bit 3 of 0x55; the next word must follow after release.
        bP[0] = popCnt[0]; bD[0] = doneCnt[0];
        push(0, 8'h55); push(0, 8'h66);
        waitPop(0, bP[0] + 1, 200);
        cycles(300);
        reset_n = 1'b0;
        #1;
        checkOutput("tx high on async reset", int'(txLine[0]), 1);
        cycles(3);
        reset_n = 1'b1;
        waitIdle(3000);
        checkOutput("pops across reset", popCnt[0] - bP[0], 2);
        checkOutput("dones across reset", doneCnt[0] - bD[0], 1);

        // tx_en dropped mid-frame with two words still queued.
        bP[0] = popCnt[0]; bD[0] = doneCnt[0];
        push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
        waitPop(0, bP[0] + 1, 200);
        cycles(20);
        txEn = '0;
        cycles(1500);
        checkOutput("pops while disabled", popCnt[0] - bP[0], 1);
        checkOutput("frame completes while disabled", doneCnt[0] - bD[0], 1);
        lvl = wp[0] - rp[0];
        checkOutput("words left queued", int'(lvl), 2);
        txEn = '1;
        cycles(1);
        checkOutput("pop right after re-enable", popCnt[0] - bP[0], 2);
        waitIdle(3000);

        // Randomised traffic under continuous, random and slow tick patterns.
        for (int chunk = 0; chunk < 3; chunk++) begin
            tickPeriod = (chunk == 0) ? 1 : ((chunk == 1) ? 0 : 3);
            for (int c = 0; c < 4000; c++) begin
                for (int i = 0; i < NI; i++) begin
                    if ($urandom_range(0, 99) < 3) txEn[i] = ~txEn[i];
                    lvl = wp[i] - rp[i];
                    if ($urandom_range(0, 99) < 2 && lvl < 8'd4) push(i, 8'($urandom));
                end
                cycles(1);
            end
        end
        txEn = '1;
        waitIdle(20000);
    endtask

    initial begin
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
